gsensor_spi_responder: RTL and testbench

GSENSOR_SPI_RESPONDER -- requirements
Module: gsensor_spi_responder

---
 rtl/gsensor_spi_responder_pkg.sv | 16 +
 rtl/gsensor_spi_responder_spi_input_sync.sv | 34 +++
 rtl/gsensor_spi_responder.sv | 185 ++++++++++++++++++
 tb/tb_gsensor_spi_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gsensor_spi_responder_pkg.sv
// Shared definitions for the G-sensor SPI responder: FSM encoding,
// command byte bit positions and register address width.
package gsensor_spi_responder_pkg;

  localparam int ADDR_W     = 6;
  localparam int REG_COUNT  = 1 << ADDR_W;
  localparam int CMD_RW_BIT = 7;
  localparam int CMD_MB_BIT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/gsensor_spi_responder_spi_input_sync.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
// IDLE_LEVEL is the value the chain resets to, so no false edge follows reset.
module spi_input_sync #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_reg <= IDLE_LEVEL;
      sync_reg <= IDLE_LEVEL;
      prev_reg <= IDLE_LEVEL;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign q    = sync_reg;
  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/gsensor_spi_responder.sv
// SPI mode-3 register-file responder modelled on an accelerometer: 64x8
// registers, read-only device ID at 0x00, single or multi-byte access.
module gsensor_spi_responder
  import gsensor_spi_responder_pkg::*;
#(
  parameter logic [7:0] DEVID            = 8'hE5,
  parameter int         MIN_CLK_PER_SCLK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [7:0]        host_wr_data,
  output logic              spi_wr_valid,
  output logic [ADDR_W-1:0] spi_wr_addr,
  output logic [7:0]        spi_wr_data
);

  if (MIN_CLK_PER_SCLK < 8) begin : g_rate_check
    $error("gsensor_spi_responder needs at least 8 clk cycles per SCLK period");
  end

  // Bit order: 0 = mosi, 1 = sclk, 2 = cs_n; idle levels match an idle bus.
  localparam logic [2:0] SYNC_IDLE = 3'b110;

  logic [2:0] sync_in;
  logic [2:0] sync_q;
  logic [2:0] sync_rise;
  logic [2:0] sync_fall;

  assign sync_in = {spi_cs_n, spi_sclk, spi_mosi};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    spi_input_sync #(
      .IDLE_LEVEL(SYNC_IDLE[gi])
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .din  (sync_in[gi]),
      .q    (sync_q[gi]),
      .rise (sync_rise[gi]),
      .fall (sync_fall[gi])
    );
  end

  logic mosi_q, cs_q, cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic unused_edges;

  assign mosi_q       = sync_q[0];
  assign cs_q         = sync_q[2];
  assign cs_rise      = sync_rise[2];
  assign cs_fall      = sync_fall[2];
  assign sclk_rise    = sync_rise[1] & ~cs_q;
  assign sclk_fall    = sync_fall[1] & ~cs_q;
  assign unused_edges = ^{sync_q[1], sync_rise[0], sync_fall[0]};

  // After reset the synchronizer starts at cs_n=1; a master that is still
  // mid-transfer would look like a CS fall, so require a real high CS first.
  logic [1:0] settle_cnt_reg;
  logic       armed_reg;
  logic       cs_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt_reg <= 2'd0;
      armed_reg      <= 1'b0;
    end else begin
      if (settle_cnt_reg != 2'd3) settle_cnt_reg <= settle_cnt_reg + 2'd1;
      if (settle_cnt_reg == 2'd3 && cs_q) armed_reg <= 1'b1;
    end
  end

  assign cs_start = cs_fall & armed_reg;

  state_t state_reg, state_next;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_in_reg;
  logic [7:0]        shift_out_reg;
  logic              rw_reg, mb_reg, miso_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        regfile_reg [REG_COUNT];
  logic [7:0]        byte_in;
  logic [7:0]        rd_data;
  logic              byte_done;
  logic              spi_we;

  assign byte_in   = {shift_in_reg[6:0], mosi_q};
  assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);
  assign spi_we    = (state_reg == ST_DATA) && byte_done && !rw_reg;
  assign rd_data   = (addr_reg == '0) ? DEVID : regfile_reg[addr_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (cs_rise) begin
      state_next = ST_IDLE;
    end else if (cs_start) begin
      state_next = ST_CMD;
    end else if (state_reg == ST_CMD && byte_done) begin
      state_next = ST_DATA;
    end
  end

  always_comb begin
    spi_miso_oe = (state_reg == ST_DATA) && rw_reg && !cs_q;
    spi_miso    = spi_miso_oe ? miso_reg : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_reg   <= 3'd0;
      shift_in_reg  <= 8'd0;
      shift_out_reg <= 8'd0;
      rw_reg        <= 1'b0;
      mb_reg        <= 1'b0;
      addr_reg      <= '0;
      miso_reg      <= 1'b0;
      spi_wr_valid  <= 1'b0;
      spi_wr_addr   <= '0;
      spi_wr_data   <= 8'd0;
    end else begin
      spi_wr_valid <= 1'b0;
      if (cs_start) begin
        bit_cnt_reg <= 3'd0;
        miso_reg    <= 1'b0;
      end else if (state_reg == ST_CMD) begin
        if (sclk_rise) begin
          shift_in_reg <= byte_in;
          bit_cnt_reg  <= bit_cnt_reg + 3'd1;
          if (byte_done) begin
            rw_reg   <= byte_in[CMD_RW_BIT];
            mb_reg   <= byte_in[CMD_MB_BIT];
            addr_reg <= byte_in[ADDR_W-1:0];
          end
        end
      end else if (state_reg == ST_DATA) begin
        if (sclk_rise) begin
          shift_in_reg <= byte_in;
          bit_cnt_reg  <= bit_cnt_reg + 3'd1;
          if (byte_done) begin
            if (!rw_reg) begin
              spi_wr_valid <= 1'b1;
              spi_wr_addr  <= addr_reg;
              spi_wr_data  <= byte_in;
            end
            if (mb_reg) addr_reg <= addr_reg + 1'b1;
          end
        end else if (sclk_fall && rw_reg) begin
          // First fall of each byte takes a fresh snapshot of the register.
          if (bit_cnt_reg == 3'd0) begin
            miso_reg      <= rd_data[7];
            shift_out_reg <= {rd_data[6:0], 1'b0};
          end else begin
            miso_reg      <= shift_out_reg[7];
            shift_out_reg <= {shift_out_reg[6:0], 1'b0};
          end
        end
      end
    end
  end

  // SPI write takes priority over a host write to the same address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regfile_reg[i] <= 8'd0;
    end else begin
      for (int i = 1; i < REG_COUNT; i++) begin
        if (spi_we && addr_reg == ADDR_W'(i))
          regfile_reg[i] <= byte_in;
        else if (host_wr_en && host_wr_addr == ADDR_W'(i))
          regfile_reg[i] <= host_wr_data;
      end
    end
  end

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// Scoreboard bench for gsensor_spi_responder: an SPI mode-3 master task
// queues expected bytes from a register-array model; monitors compare.
module tb_gsensor_spi_responder;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_cs_n, spi_sclk, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic       host_wr_en;
  logic [5:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic       spi_wr_valid;
  logic [5:0] spi_wr_addr;
  logic [7:0] spi_wr_data;

  always #5 clk = ~clk;

  gsensor_spi_responder dut (
    .clk         (clk),
    .reset       (reset),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .host_wr_en  (host_wr_en),
    .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data),
    .spi_wr_valid(spi_wr_valid),
    .spi_wr_addr (spi_wr_addr),
    .spi_wr_data (spi_wr_data)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_regs [64];
  logic [7:0]  exp_rd_q [$];
  logic [13:0] exp_wr_q [$];
  logic [7:0]  tx_buf [16];
  int          rd_bits;
  logic [7:0]  rd_shift;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [5:0] a);
    return (a == 6'd0) ? 8'hE5 : model_regs[a];
  endfunction

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    host_wr_en   = 1'b1;
    host_wr_addr = a;
    host_wr_data = d;
    @(negedge clk);
    host_wr_en = 1'b0;
    if (a != 6'd0) model_regs[a] = d;
    $display("host write addr=%02h data=%02h", a, d);
  endtask

  // Mode 3: drive mosi on SCLK fall, responder samples on rise.
  task automatic send_byte(input logic [7:0] b, input int nbits, input bit collide,
                           input logic [5:0] caddr, input logic [7:0] cval);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sclk = 1'b0;
      spi_mosi = b[i];
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b1;
      if (collide && i == 0) begin
        // Land a host write on the same clk edge as the SPI write commit.
        @(posedge clk);
        @(posedge clk);
        #1;
        host_wr_en   = 1'b1;
        host_wr_addr = caddr;
        host_wr_data = cval;
        @(posedge clk);
        #1;
        host_wr_en = 1'b0;
        check("collide_align", {31'd0, spi_wr_valid}, 32'd1);
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input int nbytes,
                          input bit collide, input logic [7:0] cval);
    logic       rw;
    logic       mb;
    logic [5:0] a;
    rw = cmd[7];
    mb = cmd[6];
    a  = cmd[5:0];
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    check("oe_cmd", {31'd0, spi_miso_oe}, 32'd0);
    send_byte(cmd, 8, 1'b0, 6'd0, 8'd0);
    check("oe_data", {31'd0, spi_miso_oe}, {31'd0, rw});
    for (int k = 0; k < nbytes; k++) begin
      if (rw) begin
        exp_rd_q.push_back(model_read(a));
      end else begin
        exp_wr_q.push_back({a, tx_buf[k]});
        if (a != 6'd0) model_regs[a] = tx_buf[k];
      end
      send_byte(rw ? 8'(k * 37) : tx_buf[k], 8, collide && (k == nbytes - 1), a, cval);
      if (mb) a = a + 6'd1;
    end
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    check("oe_idle", {31'd0, spi_miso_oe}, 32'd0);
    $display("xfer cmd=%02h rw=%0d mb=%0d bytes=%0d collide=%0d", cmd, rw, mb, nbytes, collide);
  endtask

  // Read monitor: assembles miso bits on master sample edges while driven.
  initial begin
    rd_bits  = 0;
    rd_shift = 8'd0;
    forever begin
      @(posedge spi_sclk or posedge spi_cs_n or posedge reset);
      if (reset || spi_cs_n) begin
        rd_bits = 0;
      end else if (spi_miso_oe) begin
        rd_shift = {rd_shift[6:0], spi_miso};
        rd_bits++;
        if (rd_bits == 8) begin
          rd_bits = 0;
          if (exp_rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got 0x%02h, expected no read byte", rd_shift);
          end else begin
            check("rd_data", {24'd0, rd_shift}, {24'd0, exp_rd_q.pop_front()});
          end
        end
      end
    end
  end

  // Write monitor: every cycle with spi_wr_valid consumes one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && spi_wr_valid) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got addr=%02h data=%02h, expected no write",
                   spi_wr_addr, spi_wr_data);
        end else begin
          check("wr_addr_data", {18'd0, spi_wr_addr, spi_wr_data}, {18'd0, exp_wr_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout: got no finish, expected finish within 3 ms");
    $fatal(1);
  end

  initial begin
    logic [7:0] cmd;
    reset        = 1'b1;
    spi_cs_n     = 1'b1;
    spi_sclk     = 1'b1;
    spi_mosi     = 1'b0;
    host_wr_en   = 1'b0;
    host_wr_addr = 6'd0;
    host_wr_data = 8'd0;
    for (int i = 0; i < 64; i++) model_regs[i] = 8'd0;
    repeat (4) @(negedge clk);
    check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_wr_valid", {31'd0, spi_wr_valid}, 32'd0);
    check("rst_wr_addr", {26'd0, spi_wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, spi_wr_data}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Device ID read.
    spi_xfer(8'h80, 1, 1'b0, 8'd0);

    // Multi-byte read after host loads.
    host_write(6'h32, 8'h12);
    host_write(6'h33, 8'h34);
    spi_xfer(8'hF2, 2, 1'b0, 8'd0);

    // Multi-byte write wrapping 0x3F -> 0x00, then read back across the wrap.
    tx_buf[0] = 8'hAA;
    tx_buf[1] = 8'hBB;
    spi_xfer(8'h7F, 2, 1'b0, 8'd0);
    spi_xfer(8'hFF, 2, 1'b0, 8'd0);

    // Aborted write: partial byte must leave no trace.
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_byte(8'h31, 8, 1'b0, 6'd0, 8'd0);
    send_byte(8'hC7, 5, 1'b0, 6'd0, 8'd0);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    $display("xfer cmd=31 aborted after 5 data bits");
    spi_xfer(8'hB1, 1, 1'b0, 8'd0);
    host_write(6'h31, 8'h5A);
    spi_xfer(8'hB1, 1, 1'b0, 8'd0);

    // Same-cycle SPI and host writes to 0x2D.
    tx_buf[0] = 8'h08;
    spi_xfer(8'h2D, 1, 1'b1, 8'h55);
    spi_xfer(8'hAD, 1, 1'b0, 8'd0);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) == 0) host_write(6'($urandom), 8'($urandom));
      cmd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) cmd[5:0] = 6'h3E;
      for (int k = 0; k < 4; k++) tx_buf[k] = 8'($urandom);
      spi_xfer(cmd, int'($urandom_range(1, 4)), 1'b0, 8'd0);
    end

    // Reset in the middle of a read.
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    send_byte(8'hF2, 8, 1'b0, 6'd0, 8'd0);
    send_byte(8'h00, 3, 1'b0, 6'd0, 8'd0);
    reset = 1'b1;
    #1;
    check("midrst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("midrst_miso", {31'd0, spi_miso}, 32'd0);
    for (int i = 0; i < 64; i++) model_regs[i] = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    send_byte(8'h00, 5, 1'b0, 6'd0, 8'd0);
    check("postrst_oe", {31'd0, spi_miso_oe}, 32'd0);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    $display("xfer cmd=F2 interrupted by reset");
    spi_xfer(8'h80, 1, 1'b0, 8'd0);
    spi_xfer(8'hF2, 1, 1'b0, 8'd0);

    repeat (20) @(negedge clk);
    check("rd_queue_empty", exp_rd_q.size(), 32'd0);
    check("wr_queue_empty", exp_wr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
